// File: rtl/image_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : image_pixel_streamer
//  Description : Reads an IMG_W x IMG_H 8-bit image in raster order from a
//                synchronous-read memory (1-cycle latency) and emits it as a
//                we/data_out pixel stream with start-of-line and end-of-frame
//                markers. A downstream hold stalls the stream without losing
//                or duplicating pixels; a one-entry skid catches the single
//                read that can be in flight when hold rises.
//
//  Ports       : clk        rising-edge clock
//                rst        synchronous, active-low reset
//                start      frame request, sampled only when idle
//                hold       downstream stall
//                mem_rd_en  memory read strobe
//                mem_addr   memory read address
//                mem_rdata  memory read data (cycle after mem_rd_en)
//                we         pixel valid strobe
//                data_out   pixel value
//                sol        start of line (column 0)
//                eof        last pixel of frame
//                busy       frame in progress
//                done       one-cycle pulse after last pixel
//
//  Revision    : 1.0 - initial release
// ============================================================================
module image_pixel_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              we,
    output logic [7:0]        data_out,
    output logic              sol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(IMG_H - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rd_pending;   // read issued last cycle, data on mem_rdata now
    logic               r_skid_valid;
    logic [7:0]         r_skid_data;
    logic [c_col_w-1:0] r_col;          // position of the next pixel to be emitted
    logic [c_row_w-1:0] r_row;
    logic               r_we;
    logic [7:0]         r_data;
    logic               r_sol;
    logic               r_eof;

    logic               w_rd_en;
    logic               w_emit;
    logic [7:0]         w_pix;
    logic               w_last_pix;

    // No read while stalled or while the skid is occupied: this keeps at most
    // one read in flight, so the single skid entry can never overflow.
    assign w_rd_en    = (r_state == c_st_read) && !hold && !r_skid_valid;
    assign w_emit     = !hold && (r_skid_valid || r_rd_pending);
    // The skid always holds older data than anything on mem_rdata.
    assign w_pix      = r_skid_valid ? r_skid_data : mem_rdata;
    assign w_last_pix = (r_col == c_last_col) && (r_row == c_last_row);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_rd_pending <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_sol        <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            r_rd_pending <= w_rd_en;

            // Park the in-flight read data when the consumer stalls.
            if (hold && r_rd_pending) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= mem_rdata;
            end else if (!hold && r_skid_valid) begin
                r_skid_valid <= 1'b0;
            end

            // Output register; data/markers retain their value when idle.
            r_we <= w_emit;
            if (w_emit) begin
                r_data <= w_pix;
                r_sol  <= (r_col == '0);
                r_eof  <= w_last_pix;
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_row) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_read;
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                c_st_read: begin
                    if (w_rd_en) begin
                        // Address stays on the last location once the
                        // final read has been issued.
                        if (r_addr == c_last_addr) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    // Leave once the final pixel is on the output.
                    if (r_we && r_eof) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign mem_rd_en = w_rd_en;
    assign mem_addr  = r_addr;
    assign we        = r_we;
    assign data_out  = r_data;
    assign sol       = r_sol;
    assign eof       = r_eof;
    assign busy      = (r_state == c_st_read) || (r_state == c_st_drain);
    assign done      = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_image_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_pixel_streamer
//  Description : Scoreboard bench for image_pixel_streamer with a 4x2 image,
//                memory[a] = 8'h10 + a. Stimulus pushes the expected pixel
//                stream; a monitor pops and compares on every we cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_pixel_streamer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int AW   = 3;
    localparam int NPIX = W * H;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          hold  = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic          we;
    logic [7:0]    data_out;
    logic          sol;
    logic          eof;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    image_pixel_streamer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .we        (we),
        .data_out  (data_out),
        .sol       (sol),
        .eof       (eof),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous-read memory model, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 8'h10 + 8'(mem_addr);
    end

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   pix_cnt  = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   eof_cyc  = -100;
    logic hold_q   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.d = 8'h10 + 8'(i);
            e.s = ((i % W) == 0);
            e.e = (i == NPIX - 1);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_pixel(input logic [7:0] val, input int bound);
        int n = 0;
        while (!(we && data_out == val) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!(we && data_out == val)) check("pixel_wait_timeout", int'(val), -1);
    endtask

    task automatic end_of_frame(input string name, input int npix, input int ndone);
        repeat (3) @(negedge clk);
        check({name, "_pixel_count"}, pix_cnt, npix);
        check({name, "_done_count"}, done_cnt, ndone);
        check({name, "_queue_empty"}, q.size(), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
    endtask

    // Monitor: hold seen at an edge forbids we in the following cycle.
    always @(posedge clk) hold_q <= hold;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (hold_q) check("we_after_hold", int'(we), 0);
        if (we) begin
            pix_cnt++;
            if (q.size() == 0) begin
                check("unexpected_pixel", int'(data_out), -1);
            end else begin
                e = q.pop_front();
                check("pixel_data_sol_eof", int'({data_out, sol, eof}), int'({e.d, e.s, e.e}));
            end
            if (eof) eof_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            check("done_after_eof", cyc - eof_cyc, 1);
            check("busy_low_with_done", int'(busy), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_we", int'(we), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(mem_rd_en), 0);
        rst = 1'b1;
        @(negedge clk);

        // Hold while idle has no effect
        hold = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold_busy", int'(busy), 0);
        hold = 1'b0;
        @(negedge clk);

        // Basic frame with latency and continuity
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        check("first_rd_en", int'(mem_rd_en), 1);
        check("first_rd_addr", int'(mem_addr), 0);
        check("busy_after_start", int'(busy), 1);
        @(negedge clk);
        check("no_we_yet", int'(we), 0);
        @(negedge clk);
        check("first_we_latency", int'(we), 1);
        for (int i = 1; i < NPIX; i++) begin
            @(negedge clk);
            check("we_continuous", int'(we), 1);
        end
        wait_done(10);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        end_of_frame("basic", NPIX, 1);

        // Stall mid-line after pixel 12
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        wait_pixel(8'h12, 20);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        wait_done(40);
        end_of_frame("stall_mid", NPIX, 1);

        // Stall on the last pixel
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        begin
            int n = 0;
            while (!(mem_rd_en && mem_addr == 3'd7) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("last_read_seen", int'(mem_rd_en && mem_addr == 3'd7), 1);
        end
        @(negedge clk);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        check("eof_held_off", int'(eof && we), 0);
        hold = 1'b0;
        wait_done(20);
        end_of_frame("stall_last", NPIX, 1);

        // Start while busy is ignored
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(20);
        repeat (4) @(negedge clk);
        end_of_frame("start_busy", NPIX, 1);

        // Reset mid-frame, then a full frame
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        wait_pixel(8'h13, 20);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_we", int'(we), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rd_en", int'(mem_rd_en), 0);
        q.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_we", int'(we), 0);
        check("rst_mid_pixels", pix_cnt, 4);
        check("rst_mid_no_done", done_cnt, 0);
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        pulse_start();
        wait_done(20);
        end_of_frame("after_reset", NPIX, 1);

        // Back-to-back frames with start held high
        pix_cnt = 0; done_cnt = 0;
        push_frame();
        push_frame();
        start = 1'b1;
        @(negedge clk);
        wait_done(20);
        @(negedge clk);
        @(negedge clk);
        check("retrigger_busy", int'(busy), 1);
        start = 1'b0;
        wait_done(20);
        end_of_frame("back_to_back", 2 * NPIX, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
